// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the serial-bus arbiter: FSM state encoding,
// preamble layout and a small constant helper.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ID,
        ACK_WAIT,
        COM,
        RELEASE
    } state_t;

    localparam logic [2:0] START_PATTERN = 3'b111;
    localparam int         START_LEN     = 3;
    localparam int         ID_WIDTH      = 2;
    localparam int         ACK_LEN       = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping
// around; the pointer register itself lives in the parent.
module rr_picker #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] NV = (IW + 1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   raw;

    // Rotate so that bit 0 is the master the pointer names.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                off   = IW'(i);
            end
        end
    end

    always_comb begin
        raw = {1'b0, ptr} + {1'b0, off};
        idx = (raw >= NV) ? IW'(raw - NV) : IW'(raw);
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin serial-bus arbiter: grants a master, sends the 111+id preamble,
// waits for the ack pair, holds COM until done. COM_WDOG_EN adds a COM watchdog.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ACK_TIMEOUT = 8,
    parameter  int COM_TIMEOUT = 255,
    localparam int IW          = $clog2(NUM_MASTERS)
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [NUM_MASTERS-1:0]   req,
    input  logic [2*NUM_MASTERS-1:0] slave_id,
    input  logic [NUM_MASTERS-1:0]   done,
    input  logic                     ack,
    output logic [NUM_MASTERS-1:0]   grant,
    output logic [IW-1:0]            mux_sel,
    output logic                     bus_out,
    output logic                     com,
    output logic                     busy,
    output logic                     nack
);

`ifdef COM_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    // One shared phase counter; it only has to reach the COM limit when the watchdog exists.
    localparam int CNT_TOP = max_int(max_int(START_LEN, ACK_TIMEOUT), WDOG_EN ? COM_TIMEOUT : 0);
    localparam int CW      = $clog2(CNT_TOP);
    localparam int AW      = $clog2(ACK_LEN + 1);

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [AW-1:0]         ack_run_reg, ack_run_next;
    logic [IW-1:0]         ptr_reg, idx_reg, sel_idx, pick_idx;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [ID_WIDTH-1:0]   ids [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] one_hot;
    logic                  pick_valid, nack_next;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [IW-1:0]         mux_sel_next;
    logic                  bus_out_next, com_next, busy_next;

    rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign sel_idx = (state_reg == IDLE) ? pick_idx : idx_reg;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign ids[gi]     = slave_id[ID_WIDTH*gi +: ID_WIDTH];
            assign one_hot[gi] = (sel_idx == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        nack_next  = 1'b0;
        case (state_reg)
            IDLE:     if (pick_valid) state_next = START;
            START:    if (cnt_reg == CW'(START_LEN - 1)) state_next = ID;
            ID:       if (cnt_reg == CW'(ID_WIDTH - 1)) state_next = ACK_WAIT;
            ACK_WAIT: begin
                if (ack && ack_run_reg == AW'(ACK_LEN - 1)) begin
                    state_next = COM;
                end else if (cnt_reg == CW'(ACK_TIMEOUT - 1)) begin
                    state_next = RELEASE;
                    nack_next  = 1'b1;
                end
            end
            COM: begin
                if (done[idx_reg]) begin
                    state_next = RELEASE;
                end
`ifdef COM_WDOG_EN
                else if (cnt_reg == CW'(COM_TIMEOUT - 1)) begin
                    state_next = RELEASE;
                    nack_next  = 1'b1;
                end
`endif
            end
            RELEASE:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Counters restart on every state change; a low ack breaks the pair run.
    always_comb begin
        cnt_next     = '0;
        ack_run_next = '0;
        if (state_next == state_reg) begin
            if (state_reg == START || state_reg == ID || state_reg == ACK_WAIT ||
                (WDOG_EN && state_reg == COM))
                cnt_next = cnt_reg + 1'b1;
            if (state_reg == ACK_WAIT && ack)
                ack_run_next = ack_run_reg + 1'b1;
        end
    end

    always_comb begin
        grant_next   = '0;
        mux_sel_next = '0;
        bus_out_next = 1'b0;
        com_next     = 1'b0;
        busy_next    = (state_next != IDLE);
        case (state_next)
            START, ID, ACK_WAIT, COM: begin
                grant_next   = one_hot;
                mux_sel_next = sel_idx;
            end
            default: ;
        endcase
        case (state_next)
            START:   bus_out_next = START_PATTERN[2'd2 - 2'(cnt_next)];
            ID:      bus_out_next = (cnt_next == '0) ? id_reg[1] : id_reg[0];
            COM:     com_next     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_reg     <= '0;
            ack_run_reg <= '0;
            ptr_reg     <= '0;
            idx_reg     <= '0;
            id_reg      <= '0;
            grant       <= '0;
            mux_sel     <= '0;
            bus_out     <= 1'b0;
            com         <= 1'b0;
            busy        <= 1'b0;
            nack        <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            ack_run_reg <= ack_run_next;
            grant       <= grant_next;
            mux_sel     <= mux_sel_next;
            bus_out     <= bus_out_next;
            com         <= com_next;
            busy        <= busy_next;
            nack        <= nack_next;
            if (state_reg == IDLE && pick_valid) begin
                idx_reg <= pick_idx;
                id_reg  <= ids[pick_idx];
            end
            if (state_reg == RELEASE)
                ptr_reg <= (idx_reg == IW'(NUM_MASTERS - 1)) ? '0 : idx_reg + 1'b1;
        end
    end

endmodule
